// File: rtl/id_ex_stage.sv
// id_ex_stage
// Instruction-decode stage of the 64-bit RISC-V pipeline. Decodes the IF/ID
// instruction, reads the 32 x XLEN register file (with write-back bypass),
// generates the sign-extended immediate, detects load-use hazards against the
// ID/EX register, and registers everything into the ID/EX boundary.
//
// Ports
//   clk, reset         rising-edge clock, synchronous active-low reset
//   instruction_in     instruction from IF/ID
//   inst_addr_in       instruction address from IF/ID
//   wb_reg_write/wb_rd/wb_data   register-file write-back port
//   flush              branch-taken squash from EX (beats hazard)
//   pc_write, if_id_write        upstream enables, 0 while stalling
//   inst_addr_out .. alu_op      registered ID/EX fields
//   stall_count        saturating count of stalled cycles
module id_ex_stage #(
    parameter int XLEN        = 64,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            instruction_in,
    input  logic [XLEN-1:0]        inst_addr_in,
    input  logic                   wb_reg_write,
    input  logic [4:0]             wb_rd,
    input  logic [XLEN-1:0]        wb_data,
    input  logic                   flush,
    output logic                   pc_write,
    output logic                   if_id_write,
    output logic [XLEN-1:0]        inst_addr_out,
    output logic [XLEN-1:0]        read_data1,
    output logic [XLEN-1:0]        read_data2,
    output logic [XLEN-1:0]        imm_out,
    output logic [4:0]             rs1_out,
    output logic [4:0]             rs2_out,
    output logic [4:0]             rd_out,
    output logic [3:0]             funct4_out,
    output logic                   reg_write,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   mem_to_reg,
    output logic                   alu_src,
    output logic                   branch,
    output logic [1:0]             alu_op,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [6:0]      opcode;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;

    assign opcode = instruction_in[6:0];
    assign rs1    = instruction_in[19:15];
    assign rs2    = instruction_in[24:20];
    assign rd     = instruction_in[11:7];

    // Decoded control
    logic            c_reg_write;
    logic            c_mem_read;
    logic            c_mem_write;
    logic            c_mem_to_reg;
    logic            c_alu_src;
    logic            c_branch;
    logic [1:0]      c_alu_op;
    logic [XLEN-1:0] imm;

    always_comb begin
        c_reg_write  = 1'b0;
        c_mem_read   = 1'b0;
        c_mem_write  = 1'b0;
        c_mem_to_reg = 1'b0;
        c_alu_src    = 1'b0;
        c_branch     = 1'b0;
        c_alu_op     = 2'b00;
        imm          = '0;
        case (opcode)
            OP_R: begin
                c_reg_write = 1'b1;
                c_alu_op    = 2'b10;
            end
            OP_I_ALU: begin
                c_reg_write = 1'b1;
                c_alu_src   = 1'b1;
                c_alu_op    = 2'b11;
                imm         = {{(XLEN-12){instruction_in[31]}}, instruction_in[31:20]};
            end
            OP_LOAD: begin
                c_reg_write  = 1'b1;
                c_mem_read   = 1'b1;
                c_mem_to_reg = 1'b1;
                c_alu_src    = 1'b1;
                imm          = {{(XLEN-12){instruction_in[31]}}, instruction_in[31:20]};
            end
            OP_STORE: begin
                c_mem_write = 1'b1;
                c_alu_src   = 1'b1;
                imm         = {{(XLEN-12){instruction_in[31]}},
                               instruction_in[31:25], instruction_in[11:7]};
            end
            OP_BRANCH: begin
                c_branch = 1'b1;
                c_alu_op = 2'b01;
                imm      = {{(XLEN-13){instruction_in[31]}}, instruction_in[31],
                            instruction_in[7], instruction_in[30:25],
                            instruction_in[11:8], 1'b0};
            end
            default: ;
        endcase
    end

    // Register file
    logic [XLEN-1:0] regs [32];
    logic            wb_en;
    logic [XLEN-1:0] rf_rd1;
    logic [XLEN-1:0] rf_rd2;

    assign wb_en = wb_reg_write && (wb_rd != 5'd0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Write-back data is forwarded so ID sees a value written this same cycle.
    always_comb begin
        rf_rd1 = '0;
        rf_rd2 = '0;
        if (rs1 != 5'd0) begin
            rf_rd1 = (wb_en && (wb_rd == rs1)) ? wb_data : regs[rs1];
        end
        if (rs2 != 5'd0) begin
            rf_rd2 = (wb_en && (wb_rd == rs2)) ? wb_data : regs[rs2];
        end
    end

    // Load-use hazard against the instruction currently in ID/EX
    logic hazard;
    logic stall;
    logic bubble;

    assign hazard      = mem_read && (rd_out != 5'd0) &&
                         ((rd_out == rs1) || (rd_out == rs2));
    assign stall       = hazard && !flush;
    assign bubble      = hazard || flush;
    assign pc_write    = !stall;
    assign if_id_write = !stall;

    // ID/EX register
    always_ff @(posedge clk) begin
        if (!reset) begin
            inst_addr_out <= '0;
            read_data1    <= '0;
            read_data2    <= '0;
            imm_out       <= '0;
            rs1_out       <= '0;
            rs2_out       <= '0;
            rd_out        <= '0;
            funct4_out    <= '0;
            reg_write     <= 1'b0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_to_reg    <= 1'b0;
            alu_src       <= 1'b0;
            branch        <= 1'b0;
            alu_op        <= 2'b00;
        end else begin
            inst_addr_out <= inst_addr_in;
            read_data1    <= rf_rd1;
            read_data2    <= rf_rd2;
            imm_out       <= imm;
            rs1_out       <= rs1;
            rs2_out       <= rs2;
            rd_out        <= rd;
            funct4_out    <= {instruction_in[30], instruction_in[14:12]};
            reg_write     <= bubble ? 1'b0  : c_reg_write;
            mem_read      <= bubble ? 1'b0  : c_mem_read;
            mem_write     <= bubble ? 1'b0  : c_mem_write;
            mem_to_reg    <= bubble ? 1'b0  : c_mem_to_reg;
            alu_src       <= bubble ? 1'b0  : c_alu_src;
            branch        <= bubble ? 1'b0  : c_branch;
            alu_op        <= bubble ? 2'b00 : c_alu_op;
        end
    end

    // Stall performance counter, saturating
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_count <= '0;
        end else if (stall && (stall_count != {STALL_CNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage
// Directed-vector bench for id_ex_stage. The stall counter is built narrow
// (2 bits) so that saturation is reachable in a few load-use pairs.
module tb_id_ex_stage;

    localparam int XLEN = 64;
    localparam int SCW  = 2;

    logic            clk;
    logic            reset;
    logic [31:0]     instruction_in;
    logic [XLEN-1:0] inst_addr_in;
    logic            wb_reg_write;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            flush;
    logic            pc_write;
    logic            if_id_write;
    logic [XLEN-1:0] inst_addr_out;
    logic [XLEN-1:0] read_data1;
    logic [XLEN-1:0] read_data2;
    logic [XLEN-1:0] imm_out;
    logic [4:0]      rs1_out;
    logic [4:0]      rs2_out;
    logic [4:0]      rd_out;
    logic [3:0]      funct4_out;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            alu_src;
    logic            branch;
    logic [1:0]      alu_op;
    logic [SCW-1:0]  stall_count;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] I_ADDI   = 32'h0050_0093; // addi x1,x0,5
    localparam logic [31:0] I_SD     = 32'hFE11_3C23; // sd x1,-8(x2)
    localparam logic [31:0] I_LD     = 32'h0000_B103; // ld x2,0(x1)
    localparam logic [31:0] I_ADD    = 32'h0011_01B3; // add x3,x2,x1
    localparam logic [31:0] I_ADD56  = 32'h0062_81B3; // add x3,x5,x6
    localparam logic [31:0] I_ADD02  = 32'h0020_01B3; // add x3,x0,x2
    localparam logic [31:0] I_BEQ_P8 = 32'h0000_0463; // beq x0,x0,+8
    localparam logic [31:0] I_BEQ_M4 = 32'hFE00_0EE3; // beq x0,x0,-4
    localparam logic [31:0] I_BAD    = 32'h0000_007F; // unknown opcode

    id_ex_stage #(.XLEN(XLEN), .STALL_CNT_W(SCW)) dut (
        .clk            (clk),
        .reset          (reset),
        .instruction_in (instruction_in),
        .inst_addr_in   (inst_addr_in),
        .wb_reg_write   (wb_reg_write),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .flush          (flush),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .inst_addr_out  (inst_addr_out),
        .read_data1     (read_data1),
        .read_data2     (read_data2),
        .imm_out        (imm_out),
        .rs1_out        (rs1_out),
        .rs2_out        (rs2_out),
        .rd_out         (rd_out),
        .funct4_out     (funct4_out),
        .reg_write      (reg_write),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_to_reg     (mem_to_reg),
        .alu_src        (alu_src),
        .branch         (branch),
        .alu_op         (alu_op),
        .stall_count    (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Packs {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, alu_op}
    function automatic logic [7:0] ctl();
        return {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, alu_op};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset          = 1'b0;
        instruction_in = $urandom;
        inst_addr_in   = {$urandom, $urandom};
        wb_reg_write   = 1'b1;
        wb_rd          = 5'($urandom);
        wb_data        = {$urandom, $urandom};
        flush          = 1'($urandom);

        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_ctl",    64'(ctl()), 64'h00);
            check("rst_addr",   inst_addr_out, 64'h0);
            check("rst_imm",    imm_out, 64'h0);
            check("rst_rd1",    read_data1, 64'h0);
            check("rst_idx",    64'({rs1_out, rs2_out, rd_out, funct4_out}), 64'h0);
            check("rst_stcnt",  64'(stall_count), 64'h0);
            check("rst_pcw",    64'({pc_write, if_id_write}), 64'h3);
            instruction_in = $urandom;
            wb_rd          = 5'($urandom);
            wb_data        = {$urandom, $urandom};
        end

        // Release: registers read back zero
        reset          = 1'b1;
        wb_reg_write   = 1'b0;
        flush          = 1'b0;
        instruction_in = I_ADD56;
        inst_addr_in   = 64'h0;
        #1;
        check("rel_pcw", 64'(pc_write), 64'h1);
        tick();
        check("rel_rd1", read_data1, 64'h0);
        check("rel_rd2", read_data2, 64'h0);
        check("rel_ctl", 64'(ctl()), 64'h82);

        // addi x1,x0,5
        instruction_in = I_ADDI;
        inst_addr_in   = 64'h40;
        #1;
        check("addi_pcw", 64'({pc_write, if_id_write}), 64'h3);
        tick();
        check("addi_ctl",  64'(ctl()), 64'h8B);
        check("addi_imm",  imm_out, 64'd5);
        check("addi_rd",   64'(rd_out), 64'd1);
        check("addi_addr", inst_addr_out, 64'h40);
        check("addi_pcw2", 64'(pc_write), 64'h1);

        // sd x1,-8(x2)
        instruction_in = I_SD;
        inst_addr_in   = 64'h44;
        tick();
        check("sd_ctl", 64'(ctl()), 64'h28);
        check("sd_imm", imm_out, 64'hFFFF_FFFF_FFFF_FFF8);
        check("sd_rs",  64'({rs1_out, rs2_out}), 64'({5'd2, 5'd1}));
        check("sd_f4",  64'(funct4_out), 64'hB);

        // Load-use: ld x2,0(x1) then add x3,x2,x1
        instruction_in = I_LD;
        tick();
        check("ld_ctl", 64'(ctl()), 64'hD8);
        instruction_in = I_ADD;
        #1;
        check("lu_pcw", 64'({pc_write, if_id_write}), 64'h0);
        tick();
        check("lu_stcnt",  64'(stall_count), 64'd1);
        check("lu_bubble", 64'(ctl()), 64'h00);
        check("lu_rel",    64'(pc_write), 64'h1);
        tick();
        check("lu_add",   64'(ctl()), 64'h82);
        check("lu_add_rd", 64'(rd_out), 64'd3);
        check("lu_stcnt2", 64'(stall_count), 64'd1);

        // Flush wins over hazard
        instruction_in = I_LD;
        tick();
        instruction_in = I_ADD;
        flush          = 1'b1;
        #1;
        check("fl_pcw", 64'({pc_write, if_id_write}), 64'h3);
        tick();
        check("fl_bubble", 64'(ctl()), 64'h00);
        check("fl_stcnt",  64'(stall_count), 64'd1);
        flush = 1'b0;
        tick();
        check("fl_add", 64'(ctl()), 64'h82);

        // Write-back bypass to x2, then x0 write ignored
        wb_reg_write   = 1'b1;
        wb_rd          = 5'd2;
        wb_data        = 64'hDEAD;
        instruction_in = I_ADD;
        tick();
        check("byp_rd1", read_data1, 64'hDEAD);
        check("byp_rd2", read_data2, 64'h0);
        wb_rd          = 5'd0;
        wb_data        = 64'd7;
        instruction_in = I_ADD02;
        tick();
        check("x0_rd1", read_data1, 64'h0);
        check("x0_rd2", read_data2, 64'hDEAD);
        wb_reg_write = 1'b0;

        // Branch immediates and unknown opcode
        instruction_in = I_BEQ_P8;
        tick();
        check("beq_ctl", 64'(ctl()), 64'h05);
        check("beq_imm", imm_out, 64'd8);
        instruction_in = I_BEQ_M4;
        tick();
        check("beqn_imm", imm_out, 64'hFFFF_FFFF_FFFF_FFFC);
        instruction_in = I_BAD;
        tick();
        check("nop_ctl", 64'(ctl()), 64'h00);
        check("nop_imm", imm_out, 64'h0);

        // Saturation of the stall counter (2 bits -> max 3)
        for (int k = 1; k <= 3; k++) begin
            instruction_in = I_LD;
            tick();
            instruction_in = I_ADD;
            tick();
            check("sat_cnt", 64'(stall_count), 64'((1 + k) > 3 ? 3 : (1 + k)));
            tick();
        end

        // Reset asserted mid-stall
        instruction_in = I_LD;
        tick();
        instruction_in = I_ADD;
        #1;
        check("rs_stall", 64'(pc_write), 64'h0);
        reset = 1'b0;
        tick();
        check("rs_pcw",   64'({pc_write, if_id_write}), 64'h3);
        check("rs_stcnt", 64'(stall_count), 64'd0);
        check("rs_ctl",   64'(ctl()), 64'h00);
        reset = 1'b1;
        #1;
        check("rs_rel", 64'(pc_write), 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
